// File: rtl/bru_execute_pkg.sv
// Shared definitions for the branch-resolution execute block: packet width
// macro, packet field offsets, result FIFO depth and result-entry layout.
// Optional feature macro: BRU_MISPREDICT_CHECK_EN (adds pred_taken to the
// packet and a mispredict bit to every result entry).
`ifndef BRU_EXECUTE_DEFS
`define BRU_EXECUTE_DEFS
`ifdef BRU_MISPREDICT_CHECK_EN
`define BRU_EXEPARAM_DW 268
`else
`define BRU_EXEPARAM_DW 267
`endif
`endif

package bru_execute_pkg;

  localparam int unsigned EXEPARAM_DW = `BRU_EXEPARAM_DW;

  // Packet layout, LSB first: tag, op2, op1, imm, pc, flags, [pred_taken]
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned XLEN     = 64;
  localparam int unsigned FLAG_W   = 6;
  localparam int unsigned TAG_LSB  = 0;
  localparam int unsigned OP2_LSB  = 5;
  localparam int unsigned OP1_LSB  = 69;
  localparam int unsigned IMM_LSB  = 133;
  localparam int unsigned PC_LSB   = 197;
  localparam int unsigned FLAG_LSB = 261;
  localparam int unsigned PRED_BIT = 267;

  localparam int unsigned FIFO_DEPTH = 2;

  // Compare-select flags, MSB first as they appear in the packet
  typedef struct packed {
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic bltu;
    logic bgeu;
  } bru_flags_t;

  // One result FIFO entry
  typedef struct packed {
`ifdef BRU_MISPREDICT_CHECK_EN
    logic              mispredict;
`endif
    logic              taken;
    logic [XLEN-1:0]   target;
    logic [TAG_W-1:0]  tag;
  } bru_res_t;

  localparam int unsigned RES_W = $bits(bru_res_t);

endpackage

// File: rtl/bru_cmp.sv
// Combinational branch compare and next-PC computation.
// Flags are one-hot by contract; if several are set the results are ORed.
module bru_cmp
  import bru_execute_pkg::*;
(
  input  bru_flags_t       flags_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  op1_i,
  input  logic [XLEN-1:0]  op2_i,
  output logic             taken_o,
  output logic [XLEN-1:0]  target_o
);

  logic eq_s;
  logic lts_s;
  logic ltu_s;

  // Evaluate all compare flavours, select by flag, then pick the next PC
  always_comb begin
    eq_s  = (op1_i == op2_i);
    lts_s = ($signed(op1_i) < $signed(op2_i));
    ltu_s = (op1_i < op2_i);
    taken_o = (flags_i.beq  &  eq_s)  |
              (flags_i.bne  & ~eq_s)  |
              (flags_i.blt  &  lts_s) |
              (flags_i.bge  & ~lts_s) |
              (flags_i.bltu &  ltu_s) |
              (flags_i.bgeu & ~ltu_s);
    if (taken_o) begin
      target_o = pc_i + imm_i;
    end else begin
      target_o = pc_i + 64'd4;
    end
  end

endmodule

// File: rtl/gen_dffr.sv
// Generic D flip-flop bank with asynchronous active-low reset to zero.
module gen_dffr #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  // Capture next state on every rising edge, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= {DW{1'b0}};
    end else begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/bru_execute.sv
// Branch execute stage: resolves a branch packet and queues the result in a
// 2-entry FIFO. Input ready is registered (no path from bru_res_ready).
// Optional feature macro: BRU_MISPREDICT_CHECK_EN.
module bru_execute
  import bru_execute_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         bru_exeparam_vaild,
  output logic                         bru_exeparam_ready,
  input  logic [`BRU_EXEPARAM_DW-1:0]  bru_exeparam,
  input  logic                         flush,
  output logic                         bru_res_valid,
  input  logic                         bru_res_ready,
  output logic                         bru_res_taken,
  output logic [63:0]                  bru_res_target,
  output logic [4:0]                   bru_res_tag
`ifdef BRU_MISPREDICT_CHECK_EN
  ,
  output logic                         bru_res_mispredict
`endif
);

  logic [1:0] occ_q, occ_d;
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic       rdy_q, rdy_d;
  bru_res_t   ent0_q, ent0_d;
  bru_res_t   ent1_q, ent1_d;
  bru_res_t   new_res_s;
  bru_res_t   head_s;
  logic       push_s;
  logic       pop_s;
  logic       cmp_taken_s;
  logic [XLEN-1:0] cmp_target_s;

  bru_cmp u_cmp (
    .flags_i  (bru_flags_t'(bru_exeparam[FLAG_LSB +: FLAG_W])),
    .pc_i     (bru_exeparam[PC_LSB  +: XLEN]),
    .imm_i    (bru_exeparam[IMM_LSB +: XLEN]),
    .op1_i    (bru_exeparam[OP1_LSB +: XLEN]),
    .op2_i    (bru_exeparam[OP2_LSB +: XLEN]),
    .taken_o  (cmp_taken_s),
    .target_o (cmp_target_s)
  );

  // Form the result entry for the packet currently on the input
  always_comb begin
    new_res_s        = '0;
    new_res_s.taken  = cmp_taken_s;
    new_res_s.target = cmp_target_s;
    new_res_s.tag    = bru_exeparam[TAG_LSB +: TAG_W];
`ifdef BRU_MISPREDICT_CHECK_EN
    new_res_s.mispredict = cmp_taken_s ^ bru_exeparam[PRED_BIT];
`endif
  end

  // FIFO control: flush wins over push/pop; ready reflects next occupancy
  always_comb begin
    push_s = bru_exeparam_vaild & rdy_q & ~flush;
    pop_s  = bru_res_valid & bru_res_ready & ~flush;
    occ_d  = occ_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      occ_d  = 2'd0;
      wptr_d = 1'b0;
      rptr_d = 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
      if (push_s) begin
        wptr_d = ~wptr_q;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = ~rptr_q;
      end else begin
        rptr_d = rptr_q;
      end
    end
    rdy_d = (occ_d < 2'(FIFO_DEPTH));
  end

  // Entry write: only the slot addressed by the write pointer takes new data
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (push_s && (wptr_q == 1'b0)) begin
      ent0_d = new_res_s;
    end else if (push_s) begin
      ent1_d = new_res_s;
    end else begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
    end
  end

  gen_dffr #(.DW(2))     u_occ  (.clk(CLK), .rst_n(RSTn), .dnxt(occ_d),  .qout(occ_q));
  gen_dffr #(.DW(1))     u_wptr (.clk(CLK), .rst_n(RSTn), .dnxt(wptr_d), .qout(wptr_q));
  gen_dffr #(.DW(1))     u_rptr (.clk(CLK), .rst_n(RSTn), .dnxt(rptr_d), .qout(rptr_q));
  gen_dffr #(.DW(1))     u_rdy  (.clk(CLK), .rst_n(RSTn), .dnxt(rdy_d),  .qout(rdy_q));
  gen_dffr #(.DW(RES_W)) u_ent0 (.clk(CLK), .rst_n(RSTn), .dnxt(ent0_d), .qout(ent0_q));
  gen_dffr #(.DW(RES_W)) u_ent1 (.clk(CLK), .rst_n(RSTn), .dnxt(ent1_d), .qout(ent1_q));

  // Present the head entry selected by the read pointer
  always_comb begin
    if (rptr_q) begin
      head_s = ent1_q;
    end else begin
      head_s = ent0_q;
    end
  end

  assign bru_exeparam_ready = rdy_q;
  assign bru_res_valid      = (occ_q != 2'd0);
  assign bru_res_taken      = head_s.taken;
  assign bru_res_target     = head_s.target;
  assign bru_res_tag        = head_s.tag;
`ifdef BRU_MISPREDICT_CHECK_EN
  assign bru_res_mispredict = head_s.mispredict;
`endif

endmodule

// File: tb/tb_bru_execute.sv
// Directed scoreboard bench for bru_execute. Expected results are computed
// by a small reference model when a packet is accepted and compared against
// the FIFO head each cycle.
module tb_bru_execute;
  import bru_execute_pkg::*;

  localparam logic [5:0] F_BEQ  = 6'b100000;
  localparam logic [5:0] F_BNE  = 6'b010000;
  localparam logic [5:0] F_BLT  = 6'b001000;
  localparam logic [5:0] F_BGE  = 6'b000100;
  localparam logic [5:0] F_BLTU = 6'b000010;
  localparam logic [5:0] F_BGEU = 6'b000001;

  typedef struct packed {
    logic        taken;
    logic [63:0] target;
    logic [4:0]  tag;
    logic        mis;
  } exp_t;

  logic                   CLK = 1'b0;
  logic                   RSTn;
  logic                   bru_exeparam_vaild;
  logic                   bru_exeparam_ready;
  logic [EXEPARAM_DW-1:0] bru_exeparam;
  logic                   flush;
  logic                   bru_res_valid;
  logic                   bru_res_ready;
  logic                   bru_res_taken;
  logic [63:0]            bru_res_target;
  logic [4:0]             bru_res_tag;
  logic                   mis_s;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;
  logic m_ready;

  bru_execute dut (
    .CLK                (CLK),
    .RSTn               (RSTn),
    .bru_exeparam_vaild (bru_exeparam_vaild),
    .bru_exeparam_ready (bru_exeparam_ready),
    .bru_exeparam       (bru_exeparam),
    .flush              (flush),
    .bru_res_valid      (bru_res_valid),
    .bru_res_ready      (bru_res_ready),
    .bru_res_taken      (bru_res_taken),
    .bru_res_target     (bru_res_target),
    .bru_res_tag        (bru_res_tag)
`ifdef BRU_MISPREDICT_CHECK_EN
    ,
    .bru_res_mispredict (mis_s)
`endif
  );

`ifndef BRU_MISPREDICT_CHECK_EN
  assign mis_s = 1'b0;
`endif

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [5:0] fl, input logic [63:0] pc,
                                 input logic [63:0] imm, input logic [63:0] op1,
                                 input logic [63:0] op2, input logic [4:0] tag,
                                 input logic pred);
    exp_t e;
    logic eq, lts, ltu;
    eq  = (op1 == op2);
    lts = ($signed(op1) < $signed(op2));
    ltu = (op1 < op2);
    e.taken  = (fl[5] & eq) | (fl[4] & !eq) | (fl[3] & lts) |
               (fl[2] & !lts) | (fl[1] & ltu) | (fl[0] & !ltu);
    e.target = e.taken ? (pc + imm) : (pc + 64'd4);
    e.tag    = tag;
    e.mis    = e.taken ^ pred;
    return e;
  endfunction

  task automatic check64(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] fl, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [63:0] op1,
                       input logic [63:0] op2, input logic [4:0] tag, input logic pred);
    bru_exeparam_vaild = v;
`ifdef BRU_MISPREDICT_CHECK_EN
    bru_exeparam = {pred, fl, pc, imm, op1, op2, tag};
`else
    bru_exeparam = {fl, pc, imm, op1, op2, tag};
`endif
    cur = model(fl, pc, imm, op1, op2, tag, pred);
  endtask

  // One clock: compare outputs against the model, advance across the edge
  task automatic step();
    logic push, pop;
    check64("ready", 64'(bru_exeparam_ready), 64'(m_ready));
    check64("valid", 64'(bru_res_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check64("head_taken", 64'(bru_res_taken), 64'(sb[0].taken));
      check64("head_target", bru_res_target, sb[0].target);
      check64("head_tag", 64'(bru_res_tag), 64'(sb[0].tag));
`ifdef BRU_MISPREDICT_CHECK_EN
      check64("head_mis", 64'(mis_s), 64'(sb[0].mis));
`endif
    end
    push = bru_exeparam_vaild & m_ready & ~flush;
    pop  = (sb.size() != 0) & bru_res_ready & ~flush;
    @(posedge CLK);
    if (flush) begin
      sb.delete();
    end else begin
      if (pop)  sb.delete(0);
      if (push) sb.push_back(cur);
    end
    m_ready = (sb.size() < 2);
    #1;
  endtask

  initial begin
    RSTn = 1'b0;
    flush = 1'b0;
    bru_res_ready = 1'b0;
    m_ready = 1'b0;
    drive(1'b0, 6'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    #12;
    check64("rst_ready", 64'(bru_exeparam_ready), 64'd0);
    check64("rst_valid", 64'(bru_res_valid), 64'd0);
    check64("rst_taken", 64'(bru_res_taken), 64'd0);
    check64("rst_target", bru_res_target, 64'd0);
    check64("rst_tag", 64'(bru_res_tag), 64'd0);
    check64("rst_mis", 64'(mis_s), 64'd0);
    RSTn = 1'b1;
    @(posedge CLK); #1;
    m_ready = 1'b1;
    check64("rel_ready", 64'(bru_exeparam_ready), 64'd1);

    // Basic compares, one-cycle latency
    bru_res_ready = 1'b1;
    drive(1'b1, F_BEQ, 64'h1000, 64'h20, 64'h5, 64'h5, 5'd1, 1'b0);
    step();
    check64("beq_valid", 64'(bru_res_valid), 64'd1);
    check64("beq_taken", 64'(bru_res_taken), 64'd1);
    check64("beq_target", bru_res_target, 64'h1020);
    drive(1'b1, F_BLT, 64'h2000, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd2, 1'b0);
    step();
    check64("blt_taken", 64'(bru_res_taken), 64'd1);
    drive(1'b1, F_BLTU, 64'h2000, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 1'b0);
    step();
    check64("bltu_taken", 64'(bru_res_taken), 64'd0);
    check64("bltu_target", bru_res_target, 64'h2004);
    drive(1'b1, F_BGE, 64'h2100, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 1'b0);
    step();
    drive(1'b1, F_BGEU, 64'h2200, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 1'b0);
    step();
    drive(1'b1, 6'b0, 64'h3000, 64'h40, 64'd7, 64'd7, 5'd6, 1'b0);
    step();
    drive(1'b1, F_BEQ | F_BLT, 64'h3100, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7, 1'b0);
    step();
    bru_exeparam_vaild = 1'b0;
    step();
    step();

    // Backpressure: three back-to-back packets, only two fit
    bru_res_ready = 1'b0;
    drive(1'b1, F_BNE, 64'h5000, 64'h10, 64'd1, 64'd2, 5'd8, 1'b0);
    step();
    drive(1'b1, F_BNE, 64'h5100, 64'h10, 64'd3, 64'd3, 5'd9, 1'b0);
    step();
    check64("full_ready", 64'(bru_exeparam_ready), 64'd0);
    drive(1'b1, F_BEQ, 64'h5200, 64'h10, 64'd3, 64'd3, 5'd10, 1'b0);
    step();
    check64("full_hold_tag", 64'(bru_res_tag), 64'd8);
    bru_exeparam_vaild = 1'b0;
    bru_res_ready = 1'b1;
    step();
    check64("order_tag", 64'(bru_res_tag), 64'd9);
    step();
    step();

    // Occupancy 1 with simultaneous push and pop
    bru_res_ready = 1'b0;
    drive(1'b1, F_BGE, 64'h6000, 64'h8, 64'd9, 64'd4, 5'd11, 1'b0);
    step();
    bru_res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 2 == 1) ? F_BLT : F_BGEU, 64'h7000 + (64'(i) << 4), 64'h100,
            64'(i), 64'd4, 5'(i + 12), 1'b0);
      step();
      check64("occ1_valid", 64'(bru_res_valid), 64'd1);
      check64("occ1_ready", 64'(bru_exeparam_ready), 64'd1);
    end
    bru_exeparam_vaild = 1'b0;
    step();
    step();

    // Flush at occupancy 2 with a packet offered the same cycle
    bru_res_ready = 1'b0;
    drive(1'b1, F_BEQ, 64'h8000, 64'h4, 64'd1, 64'd1, 5'd20, 1'b0);
    step();
    drive(1'b1, F_BEQ, 64'h8100, 64'h4, 64'd1, 64'd1, 5'd21, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, F_BEQ, 64'h8200, 64'h4, 64'd1, 64'd1, 5'd31, 1'b0);
    step();
    flush = 1'b0;
    bru_exeparam_vaild = 1'b0;
    check64("flush_valid", 64'(bru_res_valid), 64'd0);
    check64("flush_ready", 64'(bru_exeparam_ready), 64'd1);
    step();
    // Flush at occupancy 1 while ready: offered packet must be dropped
    drive(1'b1, F_BNE, 64'h8300, 64'h4, 64'd1, 64'd2, 5'd22, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, F_BNE, 64'h8400, 64'h4, 64'd1, 64'd2, 5'd30, 1'b0);
    step();
    flush = 1'b0;
    bru_exeparam_vaild = 1'b0;
    check64("drop_valid", 64'(bru_res_valid), 64'd0);
    bru_res_ready = 1'b1;
    step();
    step();

    // Target wrap at the top of the address space, mispredict flag
    drive(1'b1, F_BNE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'd7, 64'd7, 5'd23, 1'b1);
    step();
    check64("wrap_taken", 64'(bru_res_taken), 64'd0);
    check64("wrap_target", bru_res_target, 64'd0);
`ifdef BRU_MISPREDICT_CHECK_EN
    check64("wrap_mis", 64'(mis_s), 64'd1);
`endif
    bru_exeparam_vaild = 1'b0;
    step();
    step();

    // Reset in the middle of operation discards the queued result
    bru_res_ready = 1'b0;
    drive(1'b1, F_BEQ, 64'h9000, 64'h4, 64'd2, 64'd2, 5'd24, 1'b0);
    step();
    bru_exeparam_vaild = 1'b0;
    #2;
    RSTn = 1'b0;
    #1;
    check64("mid_rst_valid", 64'(bru_res_valid), 64'd0);
    check64("mid_rst_ready", 64'(bru_exeparam_ready), 64'd0);
    check64("mid_rst_target", bru_res_target, 64'd0);
    sb.delete();
    RSTn = 1'b1;
    @(posedge CLK); #1;
    m_ready = 1'b1;
    bru_res_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
